// File: rtl/spi_request_arbiter_pkg.sv
// Shared encodings for the SPI request arbiter: FSM states and operation codes.
package spi_request_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      LAUNCH = 2'b01,
      BUSY   = 2'b10,
      GUARD  = 2'b11
   } arb_state_e;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/spi_request_arbiter_if.sv
// Requester-side and SPI-core-side signals of the arbiter, bundled as one interface.
interface spi_request_arbiter_if
   import spi_request_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS      = 4,
   parameter int NUMBER_OF_SLAVES    = 2,
   parameter int INCOMING_DATA_WIDTH = 8,
   parameter int OUTGOING_DATA_WIDTH = 16
);
   logic [NUM_REQUESTERS-1:0]                     req;
   logic [NUM_REQUESTERS*NUMBER_OF_SLAVES-1:0]    req_slave;
   logic [NUM_REQUESTERS-1:0]                     req_operation;
   logic [NUM_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_data;
   logic [NUM_REQUESTERS-1:0]                     ack;
   logic [NUM_REQUESTERS-1:0]                     done;
   logic [INCOMING_DATA_WIDTH-1:0]                rsp_data;
   logic                                          timeout_err;
   logic                                          busy;

   logic                                          spi_enable;
   logic                                          spi_start_transaction;
   logic                                          spi_operation;
   logic                                          spi_core_reset_n;
   logic [NUMBER_OF_SLAVES-1:0]                   spi_slave;
   logic [OUTGOING_DATA_WIDTH-1:0]                spi_outgoing_data;
   logic                                          spi_end_of_transaction;
   logic [INCOMING_DATA_WIDTH-1:0]                spi_incoming_data;

   // master: requesters plus SPI core; slave: the arbiter itself
   modport master (
      output req, req_slave, req_operation, req_data,
      output spi_end_of_transaction, spi_incoming_data,
      input  ack, done, rsp_data, timeout_err, busy,
      input  spi_enable, spi_start_transaction, spi_operation, spi_core_reset_n,
      input  spi_slave, spi_outgoing_data
   );

   modport slave (
      input  req, req_slave, req_operation, req_data,
      input  spi_end_of_transaction, spi_incoming_data,
      output ack, done, rsp_data, timeout_err, busy,
      output spi_enable, spi_start_transaction, spi_operation, spi_core_reset_n,
      output spi_slave, spi_outgoing_data
   );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping to 0.
module rr_priority_picker
   import spi_request_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 4,
   parameter int IDX_W          = 2
) (
   input  logic [NUM_REQUESTERS-1:0] req,
   input  logic [IDX_W-1:0]          rr_ptr,
   output logic [IDX_W-1:0]          winner,
   output logic                      valid
);
   always_comb begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] idx;
      winner = '0;
      valid  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(NUM_REQUESTERS))
            sum = sum - (IDX_W+1)'(NUM_REQUESTERS);
         idx = sum[IDX_W-1:0];
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end
endmodule

// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter that serialises requester transactions onto one SPI core,
// with a per-transaction watchdog and an idle guard gap between transactions.
module spi_request_arbiter
   import spi_request_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS      = 4,
   parameter int NUMBER_OF_SLAVES    = 2,
   parameter int INCOMING_DATA_WIDTH = 8,
   parameter int OUTGOING_DATA_WIDTH = 16,
   parameter int TIMEOUT_CYCLES      = 1024,
   parameter int GUARD_CYCLES        = 2
) (
   input logic                  clk,
   input logic                  reset,
   spi_request_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GD_W  = $clog2(GUARD_CYCLES + 2);

   arb_state_e                     state, state_nxt;
   logic [IDX_W-1:0]               rr_ptr, winner_q, pick_idx;
   logic                           pick_vld;
   logic [WD_W-1:0]                wdog;
   logic [GD_W-1:0]                gcnt;
   logic                           done_q, op_q, live_q;
   logic [INCOMING_DATA_WIDTH-1:0] cap_q;
   logic [NUMBER_OF_SLAVES-1:0]    slave_q;
   logic [OUTGOING_DATA_WIDTH-1:0] data_q;
   logic [NUM_REQUESTERS-1:0]      win_oh;
   logic                           wd_last, guard_last;

   rr_priority_picker #(
      .NUM_REQUESTERS(NUM_REQUESTERS),
      .IDX_W         (IDX_W)
   ) u_pick (
      .req   (bus.req),
      .rr_ptr(rr_ptr),
      .winner(pick_idx),
      .valid (pick_vld)
   );

   assign win_oh     = NUM_REQUESTERS'(1) << winner_q;
   assign wd_last    = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
   // GUARD always lasts at least one cycle, even with GUARD_CYCLES = 0
   assign guard_last = (int'(gcnt) + 1 >= GUARD_CYCLES);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         winner_q <= '0;
         wdog     <= '0;
         gcnt     <= '0;
         done_q   <= 1'b0;
         op_q     <= 1'b0;
         live_q   <= 1'b0;
         cap_q    <= '0;
         slave_q  <= '0;
         data_q   <= '0;
      end else begin
         state  <= state_nxt;
         live_q <= 1'b1;
         done_q <= 1'b0;
         unique case (state)
            IDLE: if (pick_vld) begin
               winner_q <= pick_idx;
               slave_q  <= bus.req_slave[int'(pick_idx)*NUMBER_OF_SLAVES +: NUMBER_OF_SLAVES];
               op_q     <= bus.req_operation[pick_idx];
               data_q   <= bus.req_data[int'(pick_idx)*OUTGOING_DATA_WIDTH +: OUTGOING_DATA_WIDTH];
            end
            LAUNCH: begin
               rr_ptr <= (int'(winner_q) == NUM_REQUESTERS - 1) ? '0 : winner_q + 1'b1;
               wdog   <= '0;
            end
            BUSY: begin
               wdog <= wdog + 1'b1;
               gcnt <= '0;
               if (bus.spi_end_of_transaction) begin
                  cap_q  <= bus.spi_incoming_data;
                  done_q <= 1'b1;
               end
            end
            GUARD: gcnt <= gcnt + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt                 = state;
      bus.ack                   = '0;
      bus.done                  = '0;
      bus.rsp_data              = '0;
      bus.timeout_err           = 1'b0;
      bus.spi_start_transaction = 1'b0;
      bus.spi_core_reset_n      = live_q;
      unique case (state)
         IDLE: if (pick_vld) state_nxt = LAUNCH;
         LAUNCH: begin
            state_nxt                 = BUSY;
            bus.ack                   = win_oh;
            bus.spi_start_transaction = 1'b1;
         end
         BUSY: begin
            // end-of-transaction beats a watchdog expiry in the same cycle
            if (bus.spi_end_of_transaction) begin
               state_nxt = GUARD;
            end else if (wd_last) begin
               state_nxt            = GUARD;
               bus.done             = win_oh;
               bus.timeout_err      = 1'b1;
               bus.spi_core_reset_n = 1'b0;
            end
         end
         GUARD: begin
            if (done_q) begin
               bus.done = win_oh;
               if (op_q == OP_READ) bus.rsp_data = cap_q;
            end
            if (guard_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.busy              = (state != IDLE);
   assign bus.spi_enable        = live_q;
   assign bus.spi_slave         = slave_q;
   assign bus.spi_operation     = op_q;
   assign bus.spi_outgoing_data = data_q;

endmodule

// File: doc/spi_request_arbiter.md
SPI_REQUEST_ARBITER -- requirements
Module: spi_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, number of independent requesters.
REQ-002 SHALL have parameter NUMBER_OF_SLAVES, default 2, SPI slave-select count.
REQ-003 SHALL have parameters INCOMING_DATA_WIDTH, default 8, and OUTGOING_DATA_WIDTH, default 16, the SPI core data widths.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, the watchdog limit per transaction.
REQ-005 SHALL have parameter GUARD_CYCLES, default 2, the idle gap between transactions.
REQ-006 SHALL have clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have req, input, NUM_REQUESTERS, one request bit per requester.
REQ-009 SHALL have req_slave, input, NUM_REQUESTERS*NUMBER_OF_SLAVES, per-requester slave index, requester i in slice i.
REQ-010 SHALL have req_operation, input, NUM_REQUESTERS, per-requester operation, 0=read, 1=write.
REQ-011 SHALL have req_data, input, NUM_REQUESTERS*OUTGOING_DATA_WIDTH, per-requester outgoing word.
REQ-012 SHALL have ack, output, NUM_REQUESTERS, one-cycle one-hot acceptance pulse.
REQ-013 SHALL have done, output, NUM_REQUESTERS, one-cycle one-hot completion pulse.
REQ-014 SHALL have rsp_data, output, INCOMING_DATA_WIDTH, read result, valid only while done is high.
REQ-015 SHALL have timeout_err, output, 1, pulsed together with done on watchdog expiry.
REQ-016 SHALL have busy, output, 1, high in every state except IDLE.
REQ-017 SHALL have spi_enable, spi_start_transaction, spi_operation and spi_core_reset_n, outputs, 1 bit each, which drive the SPI core.
REQ-018 SHALL have spi_slave, output, NUMBER_OF_SLAVES; spi_outgoing_data, output, OUTGOING_DATA_WIDTH.
REQ-019 SHALL have spi_end_of_transaction, input, 1; spi_incoming_data, input, INCOMING_DATA_WIDTH.

Function
REQ-020 SHALL implement states IDLE, LAUNCH, BUSY and GUARD.
REQ-021 IDLE: with any req bit high, SHALL pick a winner round-robin, searching upward from rr_ptr and wrapping at NUM_REQUESTERS-1 to 0, then go to LAUNCH next cycle.
REQ-022 SHALL register the winner's slave, operation and data onto spi_slave, spi_operation and spi_outgoing_data on the IDLE-to-LAUNCH edge, and hold them stable until GUARD exits.
REQ-023 LAUNCH, lasting one cycle: SHALL assert spi_start_transaction and ack[winner], set rr_ptr=(winner+1) mod NUM_REQUESTERS, clear the watchdog, then go to BUSY.
REQ-024 The end-to-end latency SHALL be: req high in IDLE at cycle 0, ack and spi_start_transaction high at cycle 1.
REQ-025 Requesters SHALL hold req and their inputs stable until ack; the arbiter SHALL ignore req in every state except IDLE.
REQ-026 BUSY: on spi_end_of_transaction, SHALL capture spi_incoming_data on that same cycle, then next cycle pulse done[winner] with rsp_data, then go to GUARD.
REQ-027 rsp_data SHALL be the captured data for reads and zero for writes; rsp_data SHALL be zero whenever done is low.
REQ-028 BUSY: the watchdog SHALL increment each cycle; when it reaches TIMEOUT_CYCLES-1 without end-of-transaction, SHALL pulse done[winner] and timeout_err, drive rsp_data 0, drive spi_core_reset_n low for one cycle, then go to GUARD.
REQ-029 If end-of-transaction and the last watchdog cycle coincide, end-of-transaction SHALL win and there SHALL be no timeout.
REQ-030 GUARD: SHALL count GUARD_CYCLES cycles, then return to IDLE; with GUARD_CYCLES=0 it SHALL return to IDLE in one cycle.
REQ-031 spi_enable SHALL be 1 outside reset.
REQ-032 spi_end_of_transaction outside BUSY SHALL be ignored.

Reset
REQ-033 Reset SHALL force: state IDLE, rr_ptr 0, watchdog 0, ack/done/timeout_err/busy 0, rsp_data 0, spi_start_transaction 0, spi_enable 0, spi_core_reset_n 0, spi_slave/operation/outgoing_data 0.
REQ-034 Reset mid-transaction SHALL abort without any done pulse; spi_core_reset_n SHALL go high the first cycle after reset deasserts.

Structure
REQ-035 A shared package SHALL hold the state encoding constants (IDLE=2'b00, LAUNCH=2'b01, BUSY=2'b10, GUARD=2'b11) and the READ/WRITE operation constants.
REQ-036 A sub-module rr_priority_picker SHALL be used: combinational, taking the req vector and rr_ptr and returning winner index and valid.

Verification
REQ-037 Single write: req=4'b0001, data 16'hA55A, op=1 -> ack[0] at cycle 1; spi_outgoing_data=16'hA55A; done[0] one cycle after end-of-transaction; rsp_data=0.
REQ-038 Read: requester 2, slave 1, SPI model returns 8'h3C -> done[2] with rsp_data=8'h3C; spi_slave=1 throughout.
REQ-039 Fairness: req=4'b1111 held, re-raised after each ack -> grant order 0,1,2,3,0; GUARD_CYCLES idle cycles between transactions.
REQ-040 Timeout: model never asserts end-of-transaction, TIMEOUT_CYCLES=16 -> done and timeout_err at cycle 16 after LAUNCH; spi_core_reset_n low for one cycle.
REQ-041 Coincidence: end-of-transaction on the last watchdog cycle -> done, no timeout_err.
REQ-042 Reset asserted in BUSY -> all outputs at reset values next cycle, no done; a new req after release is granted to requester 0 first.
